// File: rtl/ray_issue_scheduler.sv
// Raster ray issue scheduler: hands SDF pipeline slots to new pixel rays or recirculating rays, and tracks rays in flight.
// Optional `RAY_SCHED_CONT_EN: restart the next frame straight from DONE without waiting for start.
module ray_issue_scheduler #(
  parameter int H_RES        = 1280,
  parameter int V_RES        = 720,
  parameter int MAX_INFLIGHT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        recirc_valid,
  input  logic        retire_valid,
  output logic        issue_new,
  output logic        issue_recirc,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [19:0] pix_addr,
  output logic [4:0]  inflight,
  output logic        busy,
  output logic        frame_done,
  output logic        cam_latch,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [10:0] X_LAST  = 11'(H_RES - 1);
  localparam logic [10:0] Y_LAST  = 11'(V_RES - 1);
  localparam logic [4:0]  INF_MAX = 5'(MAX_INFLIGHT);

  state_t state;
  logic   inflight_full;
  logic   last_pix;
  logic   retire_ok;

  always_comb begin
    inflight_full = (inflight >= INF_MAX);
    issue_recirc  = (state != IDLE) && recirc_valid;
    issue_new     = (state == ISSUE) && !recirc_valid && !inflight_full;
    last_pix      = (pix_x == X_LAST) && (pix_y == Y_LAST);
    retire_ok     = retire_valid && (inflight != 5'd0);
    busy          = (state != IDLE);
    frame_done    = (state == DONE);
    cam_latch     = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pix_x    <= '0;
      pix_y    <= '0;
      pix_addr <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      // Sticky: stray retire/recirc with nothing resident, or an over-issue.
      if ((retire_valid && inflight == 5'd0) ||
          (recirc_valid && inflight == 5'd0) ||
          (issue_new && inflight_full))
        err <= 1'b1;

      if (issue_new && !retire_ok)
        inflight <= inflight + 5'd1;
      else if (!issue_new && retire_ok)
        inflight <= inflight - 5'd1;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= ISSUE;
            pix_x    <= '0;
            pix_y    <= '0;
            pix_addr <= '0;
          end
        end
        ISSUE: begin
          if (issue_new) begin
            if (pix_x == X_LAST) begin
              pix_x <= '0;
              pix_y <= pix_y + 11'd1;
            end else begin
              pix_x <= pix_x + 11'd1;
            end
            pix_addr <= pix_addr + 20'd1;
            if (last_pix)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == 5'd0)
            state <= DONE;
        end
        DONE: begin
`ifdef RAY_SCHED_CONT_EN
          state    <= ISSUE;
          pix_x    <= '0;
          pix_y    <= '0;
          pix_addr <= '0;
`else
          state    <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
